// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES hash-result words from memory and reports the smallest one and its index.
// Optional early exit on the first word below target: define SCAN_EARLY_EXIT_EN.
module hash_result_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = $clog2(NUM_NONCES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       output_addr,
    input  logic [31:0]       target,
    output logic              done,
    output logic              found,
    output logic [IDX_W-1:0]  best_nonce,
    output logic [31:0]       best_hash,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_cnt;
    logic [15:0]      r_mem_addr;
    logic [31:0]      r_target;
    logic             r_done;
    logic             r_found;
    logic [IDX_W-1:0] r_best_nonce;
    logic [31:0]      r_best_hash;

    logic             r_v1;
    logic             r_v2;
    logic [IDX_W-1:0] r_idx1;
    logic [IDX_W-1:0] r_idx2;
    logic [31:0]      r_min_hash;
    logic [IDX_W-1:0] r_min_idx;

    logic w_start;
    logic w_lower;
    logic w_last;
    logic w_hit;

    assign w_start = (r_state == S_IDLE) && start;
    assign w_lower = mem_read_data < r_min_hash;
    assign w_last  = r_v2 && (r_idx2 == LAST_IDX);

`ifdef SCAN_EARLY_EXIT_EN
    assign w_hit = r_v2 && (mem_read_data < r_target);
`else
    assign w_hit = 1'b0;
`endif

    // Control: address issue, state sequencing and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_target     <= '0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_best_nonce <= '0;
            r_best_hash  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_READ;
                        r_mem_addr   <= output_addr;
                        r_cnt        <= '0;
                        r_target     <= target;
                        r_done       <= 1'b0;
                        r_found      <= 1'b0;
                        r_best_nonce <= '0;
                        r_best_hash  <= '0;
                    end
                end
                S_READ: begin
                    if (w_hit) begin
                        r_state <= S_DONE;
                    end else if (r_cnt == LAST_IDX) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt      <= r_cnt + IDX_W'(1);
                        r_mem_addr <= r_mem_addr + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (w_hit || w_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_done       <= 1'b1;
                    r_found      <= r_min_hash < r_target;
                    r_best_nonce <= r_min_idx;
                    r_best_hash  <= r_min_hash;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Read-return pipeline and running minimum; a hit flushes in-flight reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_idx1     <= '0;
            r_idx2     <= '0;
            r_min_hash <= '1;
            r_min_idx  <= '0;
        end else begin
            r_v1   <= (r_state == S_READ) && !w_hit;
            r_v2   <= r_v1 && !w_hit;
            r_idx1 <= r_cnt;
            r_idx2 <= r_idx1;
            // All-ones seed with index 0 keeps the earliest word on an all-ones region.
            if (w_start) begin
                r_min_hash <= '1;
                r_min_idx  <= '0;
            end else if (r_v2 && w_lower) begin
                r_min_hash <= mem_read_data;
                r_min_idx  <= r_idx2;
            end
        end
    end

    assign done           = r_done;
    assign found          = r_found;
    assign best_nonce     = r_best_nonce;
    assign best_hash      = r_best_hash;
    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = 32'd0;

endmodule

// File: tb/tb_hash_result_scanner.sv
// Self-checking bench for hash_result_scanner with a two-stage read-latency memory model.
module tb_hash_result_scanner;
    localparam int N  = 16;
    localparam int IW = $clog2(N);
`ifdef SCAN_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   output_addr = '0;
    logic [31:0]   target = '0;
    logic          done;
    logic          found;
    logic [IW-1:0] best_nonce;
    logic [31:0]   best_hash;
    logic          mem_clk;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data = '0;
    logic [15:0]   mem_addr_q = '0;
    logic [31:0]   mem [0:65535];

    int total = 0;
    int bad = 0;

    hash_result_scanner #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .output_addr(output_addr),
        .target(target), .done(done), .found(found), .best_nonce(best_nonce),
        .best_hash(best_hash), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory samples the address on one edge and presents data on the next.
    always @(posedge clk) begin
        mem_addr_q    <= mem_addr;
        mem_read_data <= mem[mem_addr_q];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_scan(input logic [15:0] base, input logic [31:0] tgt, input bit noise,
                           input string name);
        int          hit;
        int          exp_idx;
        int          exp_edge;
        int          cap;
        logic [31:0] exp_hash;
        logic        exp_found;
        logic [31:0] w;
        logic [15:0] exp_a;
        hit = -1;
        exp_idx = 0;
        exp_hash = mem[base];
        for (int i = 0; i < N; i++) begin
            w = mem[base + 16'(i)];
            if (w < exp_hash) begin
                exp_hash = w;
                exp_idx = i;
            end
            if (hit < 0 && w < tgt) hit = i;
        end
        if (EE && hit >= 0) begin
            exp_idx  = hit;
            exp_hash = mem[base + 16'(hit)];
            exp_edge = hit + 4;
            cap      = (hit + 2 < N - 1) ? hit + 2 : N - 1;
        end else begin
            exp_edge = N + 3;
            cap      = N - 1;
        end
        exp_found = exp_hash < tgt;

        output_addr = base;
        target = tgt;
        start = 1'b1;
        tick();
        start = 1'b0;
        output_addr = 16'($urandom);
        target = $urandom;
        for (int j = 0; j < exp_edge; j++) begin
            exp_a = base + 16'((j < cap) ? j : cap);
            total++;
            if (mem_addr !== exp_a) begin
                bad++;
                $display("FAIL %s_addr edge=%0d got=%h exp=%h", name, j, mem_addr, exp_a);
            end
            total++;
            if (mem_we !== 1'b0 || mem_write_data !== 32'd0) begin
                bad++;
                $display("FAIL %s_we edge=%0d got_we=%b got_wd=%h exp=0", name, j, mem_we, mem_write_data);
            end
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL %s_done_early edge=%0d got=%b exp=0", name, j, done);
            end
            start = (noise && (j + 1 < exp_edge)) ? 1'($urandom) : 1'b0;
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (done !== 1'b1) begin
                bad++;
                $display("FAIL %s_done edge=%0d got=%b exp=1", name, exp_edge + k, done);
            end
            total++;
            if (best_nonce !== IW'(exp_idx)) begin
                bad++;
                $display("FAIL %s_nonce got=%0d exp=%0d", name, best_nonce, exp_idx);
            end
            total++;
            if (best_hash !== exp_hash) begin
                bad++;
                $display("FAIL %s_hash got=%h exp=%h", name, best_hash, exp_hash);
            end
            total++;
            if (found !== exp_found) begin
                bad++;
                $display("FAIL %s_found got=%b exp=%b", name, found, exp_found);
            end
            total++;
            if (mem_addr !== base + 16'(cap)) begin
                bad++;
                $display("FAIL %s_addr_hold got=%h exp=%h", name, mem_addr, base + 16'(cap));
            end
            tick();
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if (done !== 1'b0 || found !== 1'b0 || best_nonce !== '0 || best_hash !== 32'd0 ||
            mem_addr !== 16'd0) begin
            bad++;
            $display("FAIL %s got done=%b found=%b nonce=%0d hash=%h addr=%h exp=all zero",
                     name, done, found, best_nonce, best_hash, mem_addr);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) tick();
        check_zero("reset_hold");
        reset_n = 1'b1;
        repeat (4) tick();
        check_zero("idle_no_start");
    endtask

    task automatic test_descending;
        for (int i = 0; i < N; i++) mem[16'h0040 + 16'(i)] = 32'hF000_0000 - 32'(i);
        do_scan(16'h0040, 32'h8000_0000, 1'b0, "desc");
    endtask

    task automatic test_single_low;
        for (int i = 0; i < N; i++) mem[16'h1000 + 16'(i)] = 32'hFFFF_FFFF;
        mem[16'h1005] = 32'h0000_1234;
        do_scan(16'h1000, 32'h0001_0000, 1'b0, "single_low");
    endtask

    task automatic test_tie;
        for (int i = 0; i < N; i++) mem[16'h2000 + 16'(i)] = 32'h0000_1000 + ($urandom & 32'h00FF_FFFF);
        mem[16'h2003] = 32'h0000_0010;
        mem[16'h2009] = 32'h0000_0010;
        do_scan(16'h2000, 32'h0000_0010, 1'b1, "tie");
    endtask

    task automatic test_wrap;
        for (int i = 0; i < N; i++) mem[16'hFFF8 + 16'(i)] = $urandom | 32'h1000_0000;
        do_scan(16'hFFF8, 32'h0800_0000, 1'b0, "wrap");
    endtask

    task automatic test_random;
        logic [15:0] base;
        logic [31:0] tgt;
        for (int t = 0; t < 8; t++) begin
            base = 16'($urandom);
            for (int i = 0; i < N; i++) mem[base + 16'(i)] = $urandom | 32'h4000_0000;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                mem[base + 16'($urandom_range(0, N - 1))] = $urandom_range(0, 32'h3FFF_FFFF);
            case ($urandom_range(0, 2))
                0:       tgt = 32'd0;
                1:       tgt = 32'h4000_0000;
                default: tgt = $urandom;
            endcase
            do_scan(base, tgt, 1'b1, "random");
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < N; i++) mem[16'h0300 + 16'(i)] = $urandom;
        output_addr = 16'h0300;
        target = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid_async");
        tick();
        check_zero("reset_mid_held");
        reset_n = 1'b1;
        repeat (3) tick();
        check_zero("reset_mid_stale");
        do_scan(16'h0300, 32'd0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_hash;
        int          exp_idx;
        logic        exp_done;
        for (int i = 0; i < N; i++) mem[16'h0500 + 16'(i)] = $urandom;
        exp_hash = mem[16'h0500];
        exp_idx = 0;
        for (int i = 1; i < N; i++) begin
            if (mem[16'h0500 + 16'(i)] < exp_hash) begin
                exp_hash = mem[16'h0500 + 16'(i)];
                exp_idx = i;
            end
        end
        output_addr = 16'h0500;
        target = 32'd0;
        for (int e = 0; e <= 42; e++) begin
            start = (e < 40);
            tick();
            exp_done = (e == N + 3) || (e >= 2 * N + 7);
            total++;
            if (done !== exp_done) begin
                bad++;
                $display("FAIL b2b_done edge=%0d got=%b exp=%b", e, done, exp_done);
            end
        end
        start = 1'b0;
        total++;
        if (best_nonce !== IW'(exp_idx) || best_hash !== exp_hash || found !== 1'b0) begin
            bad++;
            $display("FAIL b2b_result got=%0d/%h/%b exp=%0d/%h/0", best_nonce, best_hash, found,
                     exp_idx, exp_hash);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        test_reset();
        test_descending();
        test_single_low();
        test_tie();
        test_wrap();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
